// File: rtl/pipe_loopback.sv
// pipe_loopback: buffered, mode-selectable echo engine between a pipe source and sink.
// Modes: 00 echo, 01 line-buffered echo, 10 uppercase echo, 11 sink; plus counters and activity stretcher.
module pipe_loopback #(
    parameter int         DataWidth      = 8,
    parameter int         Depth          = 16,
    parameter logic [7:0] LineChar       = 8'h0D,
    parameter int         ActivityCycles = 2400000,
    parameter int         CountWidth     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [DataWidth-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DataWidth-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(Depth):0] level,
    output logic [CountWidth-1:0]  rx_count,
    output logic [CountWidth-1:0]  tx_count,
    output logic                   activity
);
    localparam int AW  = $clog2(Depth);
    localparam int PW  = AW + 1;
    localparam int ACW = $clog2(ActivityCycles + 1);
    localparam logic [PW-1:0]  DEPTH_P  = PW'(Depth);
    localparam logic [ACW-1:0] ACT_LOAD = ACW'(ActivityCycles - 1);
    localparam logic [1:0] MODE_ECHO  = 2'b00;
    localparam logic [1:0] MODE_LINE  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_SINK  = 2'b11;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        logic [7:0] r;
        if (c >= 8'h61 && c <= 8'h7A) begin
            r = c - 8'h20;
        end else begin
            r = c;
        end
        return r;
    endfunction

    logic [DataWidth-1:0]  r_mem [Depth];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_commit_ptr;
    logic                  r_commit_all;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CountWidth-1:0] r_rx_count;
    logic [CountWidth-1:0] r_tx_count;
    logic [ACW-1:0]        r_act_cnt;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_store;
    logic                 w_release;
    logic [PW-1:0]        w_level;
    logic [PW-1:0]        w_wr_next;
    logic [PW-1:0]        w_rd_next;
    logic [PW-1:0]        w_commit_next;
    logic [PW-1:0]        w_level_next;
    logic [DataWidth-1:0] w_wdata;

    // Transfer detection and next-state pointer arithmetic.
    always_comb begin
        w_push  = in_valid && r_in_ready;
        w_pop   = r_out_valid && out_ready;
        w_level = r_wr_ptr - r_rd_ptr;
        // The full guard only matters right after leaving sink mode with a full buffer.
        w_store   = w_push && (mode != MODE_SINK) && (w_level != DEPTH_P);
        w_wr_next = w_store ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
        w_rd_next = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
        w_level_next = w_wr_next - w_rd_next;
        // Commit lags the write pointer by one edge so a stored byte is visible one cycle later.
        if (r_commit_all || (mode != MODE_LINE)) begin
            w_commit_next = r_wr_ptr;
        end else begin
            w_commit_next = r_commit_ptr;
        end
        w_release = (mode != MODE_LINE) || (w_level_next == DEPTH_P) ||
                    (w_store && (in_data[7:0] == LineChar));
        w_wdata = in_data;
        case (mode)
            MODE_UPPER: w_wdata[7:0] = to_upper(in_data[7:0]);
            MODE_ECHO, MODE_LINE, MODE_SINK: w_wdata = in_data;
            default:    w_wdata = in_data;
        endcase
    end

    // Pointer, flag and counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_commit_all <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_rx_count   <= '0;
            r_tx_count   <= '0;
            r_act_cnt    <= '0;
        end else begin
            r_wr_ptr     <= w_wr_next;
            r_rd_ptr     <= w_rd_next;
            r_commit_ptr <= w_commit_next;
            r_commit_all <= w_release;
            r_in_ready   <= (w_level_next < DEPTH_P) || (mode == MODE_SINK);
            r_out_valid  <= (w_rd_next != w_commit_next);
            if (w_push) begin
                r_rx_count <= r_rx_count + CountWidth'(1);
            end
            if (w_pop) begin
                r_tx_count <= r_tx_count + CountWidth'(1);
            end
            if (w_push || w_pop) begin
                r_act_cnt <= ACT_LOAD;
            end else if (r_act_cnt != '0) begin
                r_act_cnt <= r_act_cnt - ACW'(1);
            end
        end
    end

    // Storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign level     = w_level;
    assign rx_count  = r_rx_count;
    assign tx_count  = r_tx_count;
    assign activity  = (r_act_cnt != '0) || w_push || w_pop;

endmodule
